gate_truth_checker: RTL
=======================

# gate_truth_checker

Sequential truth-table sweeper and checker for two-input combinational gates in the simple-circuit suite. On `start` it drives the four input vectors into a gate DUT, waits a programmable settle time, then samples and compares the DUT output against a selected golden function. It reports a mismatch count, the first failing vector and a pass/fail verdict, turning a buggy gate such as an OR that behaves like an AND into a self-checking hardware result.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  sweep request; sampled only in IDLE.
- `op`  in  2  golden function: 00 AND, 01 OR, 10 XOR, 11 NAND; latched on accepted `start`.
- `dut_a`  out  1  DUT input a (MSB of the vector index).
- `dut_b`  out  1  DUT input b (LSB of the vector index).
- `dut_out`  in  1  DUT output.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE, inclusive.
- `done`  out  1  one-cycle pulse when the sweep ends.
- `pass`  out  1  1 if `err_count`==0; updated at `done`, held until the next accepted `start`.
- `err_count`  out  3  number of mismatching vectors, 0..4.
- `first_fail_vec`  out  2  {a,b} of the first mismatch; valid when `first_fail_valid`=1.
- `first_fail_valid`  out  1  set on the first mismatch of a sweep.

## Operation
- FSM states are IDLE, SETTLE, SAMPLE and DONE.
- **IDLE:**
  - If `start`=1, latch `op`.
  - Clear `err_count`, `first_fail_valid` and `pass`.
  - Set vector index to 0, load the settle counter with `SETTLE_CYCLES`, then go to SETTLE.
- **SETTLE:**
  - `dut_a`/`dut_b` equal the vector index.
  - Decrement the counter; when it reaches 0, go to SAMPLE.
- **SAMPLE:**
  - Compute expected = f(op, a, b).
  - If `dut_out` != expected, increment `err_count`.
  - On the first mismatch only, capture `first_fail_vec` and set `first_fail_valid`.
  - If the index is 3, go to DONE. Otherwise increment the index, reload the counter and go to SETTLE.
- **DONE:**
  - Assert `done` for one cycle.
  - `pass` <= (`err_count`==0); this uses the final count, including the last sample.
  - Go to IDLE.
- Vector order is fixed: 00, 01, 10, 11.
- `dut_a`/`dut_b` hold their last value in DONE and IDLE.
- Result outputs hold in IDLE until the next accepted `start`.
- `start` is ignored while `busy`=1.
- A change to `op` mid-sweep has no effect, because `op` is latched.
- `err_count` cannot exceed 4, so no saturation logic is needed.

## Timing
- Reset values: state IDLE, and `dut_a`, `dut_b`, `busy`, `done`, `pass`, `err_count`, `first_fail_vec` and `first_fail_valid` are all 0.
- Reset asserted mid-sweep aborts immediately to the reset values. No `done` is produced for the aborted sweep.
- Counting `start` accepted at cycle 0:
  - Vector k is driven from cycle 1+k·(S+1), where S = `SETTLE_CYCLES`.
  - Vector k is sampled in cycle (k+1)·(S+1).
  - `done` is high in cycle 4·(S+1)+1, which is cycle 13 for S=2.
  - `busy` is high in cycles 1..4·(S+1)+1.
- `err_count` and `first_fail_*` update on the edge ending the SAMPLE cycle.
- `pass` is valid from the `done` cycle onward.
- `start` high in the `done` cycle is ignored. `start` in the following IDLE cycle is accepted, giving back-to-back sweeps with one idle cycle between them.

## Configuration
- Macro: `GATE_CHECK_STOP_ON_FAIL_EN`.
- **Defined:** a mismatching SAMPLE goes directly to DONE. `err_count` then ends at 0 or 1, and the sweep is shortened.
- **Undefined:** all four vectors are always checked, and the timing is exactly as in the Timing section.

## Test plan
- `op`=01 (OR), DUT implements AND, S=2, macro undefined -> `err_count`=2, `first_fail_vec`=01, `first_fail_valid`=1, `pass`=0, `done` in cycle 13.
- `op`=01, DUT implements correct OR -> `err_count`=0, `first_fail_valid`=0, `pass`=1, `done` in cycle 13.
- `op`=11 (NAND), DUT implements AND -> `err_count`=4, `first_fail_vec`=00, `pass`=0.
- Macro defined, `op`=01, DUT implements AND -> `err_count`=1, `first_fail_vec`=01, `done` in cycle 7.
- Pulse `start` again and toggle `op` at cycle 5 of a correct OR sweep -> no restart, result unchanged (`pass`=1), `done` still in cycle 13.
- Drop `rst_n` at cycle 6 -> all outputs 0 asynchronously and no `done`. Release reset and start again -> the sweep completes normally.

Source files
------------

// File: rtl/gate_truth_checker_if.sv
// Handshake bundle between gate_truth_checker and the environment that owns
// the gate under test and issues sweep requests.
interface gate_truth_checker_if;
   logic       start;
   logic [1:0] op;
   logic       dut_a;
   logic       dut_b;
   logic       dut_out;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_count;
   logic [1:0] first_fail_vec;
   logic       first_fail_valid;

   modport master (
      output start, op, dut_out,
      input  dut_a, dut_b, busy, done, pass, err_count, first_fail_vec, first_fail_valid
   );

   modport slave (
      input  start, op, dut_out,
      output dut_a, dut_b, busy, done, pass, err_count, first_fail_vec, first_fail_valid
   );
endinterface

// File: rtl/gate_truth_checker.sv
// Truth-table sweeper for a two-input gate: drives 00,01,10,11, samples after a settle time,
// counts mismatches against a golden op. Option: GATE_CHECK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
//
// state  | meaning
// IDLE   | waiting for start; results held
// SETTLE | vector driven, settle counter running
// SAMPLE | compare dut_out against golden function
// DONE   | one-cycle done pulse, pass valid
module gate_truth_checker #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   gate_truth_checker_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

   state_t     state, state_nxt;
   logic [1:0] op_q, op_nxt;
   logic [1:0] idx_q, idx_nxt;
   logic [3:0] cnt_q, cnt_nxt;
   logic [2:0] err_q, err_nxt;
   logic [1:0] ffv_q, ffv_nxt;
   logic       ffval_q, ffval_nxt;
   logic       pass_q, pass_nxt;
   logic       expected;
   logic       mismatch;
   logic       last_vec;

   always_comb begin
      unique case (op_q)
         2'b00:   expected = idx_q[1] & idx_q[0];
         2'b01:   expected = idx_q[1] | idx_q[0];
         2'b10:   expected = idx_q[1] ^ idx_q[0];
         default: expected = ~(idx_q[1] & idx_q[0]);
      endcase
   end

   assign mismatch = (bus.dut_out != expected);

`ifdef GATE_CHECK_STOP_ON_FAIL_EN
   assign last_vec = (idx_q == 2'd3) || mismatch;
`else
   assign last_vec = (idx_q == 2'd3);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         op_q    <= 2'd0;
         idx_q   <= 2'd0;
         cnt_q   <= 4'd0;
         err_q   <= 3'd0;
         ffv_q   <= 2'd0;
         ffval_q <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         op_q    <= op_nxt;
         idx_q   <= idx_nxt;
         cnt_q   <= cnt_nxt;
         err_q   <= err_nxt;
         ffv_q   <= ffv_nxt;
         ffval_q <= ffval_nxt;
         pass_q  <= pass_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      op_nxt    = op_q;
      idx_nxt   = idx_q;
      cnt_nxt   = cnt_q;
      err_nxt   = err_q;
      ffv_nxt   = ffv_q;
      ffval_nxt = ffval_q;
      pass_nxt  = pass_q;

      unique case (state)
         IDLE: begin
            if (bus.start) begin
               op_nxt    = bus.op;
               err_nxt   = 3'd0;
               ffval_nxt = 1'b0;
               pass_nxt  = 1'b0;
               idx_nxt   = 2'd0;
               cnt_nxt   = SETTLE_LOAD;
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            cnt_nxt = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_nxt = SAMPLE;
         end
         SAMPLE: begin
            if (mismatch) begin
               err_nxt = err_q + 3'd1;
               if (!ffval_q) begin
                  ffv_nxt   = idx_q;
                  ffval_nxt = 1'b1;
               end
            end
            // pass is resolved on entry to DONE so it is already valid while done is high
            if (last_vec) begin
               pass_nxt  = (err_nxt == 3'd0);
               state_nxt = DONE;
            end else begin
               idx_nxt   = idx_q + 2'd1;
               cnt_nxt   = SETTLE_LOAD;
               state_nxt = SETTLE;
            end
         end
         DONE: begin
            pass_nxt  = (err_q == 3'd0);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.dut_a            = idx_q[1];
   assign bus.dut_b            = idx_q[0];
   assign bus.busy             = (state != IDLE);
   assign bus.done             = (state == DONE);
   assign bus.pass             = pass_q;
   assign bus.err_count        = err_q;
   assign bus.first_fail_vec   = ffv_q;
   assign bus.first_fail_valid = ffval_q;

endmodule
